// File: rtl/axi_stream_if.sv
// axi_stream_if
// Byte-stream handshake bundle shared by every stream port of uart_link_host.
//   tdata  : payload byte (DATA_WIDTH bits)
//   tvalid : source has a byte on tdata
//   tready : sink accepts the byte this cycle
//   tlast  : final byte of a message
// master drives tdata/tvalid/tlast, slave drives tready.
interface axi_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/uart_link_host.sv
// uart_link_host
// Host-side endpoint of the UART mux framing.
// TX: arbitrates five host sources (info > instr > payload > eth > parrot)
//     and serialises each winner as a type-tagged message on uart_tx.
// RX: parses [header][data] pairs from uart_rx and routes the data byte to
//     the stream selected by the header; unknown headers are dropped and
//     counted in bad_hdr_cnt (saturating).
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   uart_tx  (master)   bytes toward the mux
//   uart_rx  (slave)    bytes from the mux
//   instr_in (slave)    instruction bytes, type 4
//   eth_in   (slave)    Ethernet frame bytes, type 1
//   payload_in (slave)  payload bytes, type 6
//   info_valid/ready, info_addr, info_data   info register write, type 7
//   parrot_req/ready    parrot request, type 0 (header only)
//   rest_out/eth_out/status_out/echo_out (master)  data of type 3/2/5/0
//   bad_hdr_cnt         count of unrecognised response headers
//
// TX states
//   TX_IDLE | arbitrate sources, one ready granted per cycle
//   TX_HDR  | header byte on uart_tx
//   TX_B1   | first data byte on uart_tx
//   TX_B2   | second data byte (INFO only)
// RX states
//   RX_HDR  | waiting for a response header
//   RX_DATA | waiting for the data byte of a recognised header
//   RX_OUT  | data byte held on the selected output stream
module uart_link_host #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axi_stream_if.master         uart_tx,
  axi_stream_if.slave          uart_rx,
  axi_stream_if.slave          instr_in,
  axi_stream_if.slave          eth_in,
  axi_stream_if.slave          payload_in,
  input  logic                 info_valid,
  output logic                 info_ready,
  input  logic [4:0]           info_addr,
  input  logic [7:0]           info_data,
  input  logic                 parrot_req,
  output logic                 parrot_ready,
  axi_stream_if.master         rest_out,
  axi_stream_if.master         eth_out,
  axi_stream_if.master         status_out,
  axi_stream_if.master         echo_out,
  output logic [CNT_WIDTH-1:0] bad_hdr_cnt
);

  typedef logic [DATA_WIDTH-1:0] byte_t;

  localparam byte_t T_PARROT  = byte_t'(0);
  localparam byte_t T_ETH_IN  = byte_t'(1);
  localparam byte_t T_ETH_OUT = byte_t'(2);
  localparam byte_t T_REST    = byte_t'(3);
  localparam byte_t T_INSTR   = byte_t'(4);
  localparam byte_t T_STATUS  = byte_t'(5);
  localparam byte_t T_PAYLOAD = byte_t'(6);
  localparam byte_t T_INFO    = byte_t'(7);

  typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_B1, TX_B2} tx_state_e;
  typedef enum logic [1:0] {RX_HDR, RX_DATA, RX_OUT} rx_state_e;

  // Source tlast carries no meaning on this link.
  logic unused_tlast;
  assign unused_tlast = uart_rx.tlast ^ instr_in.tlast ^ eth_in.tlast ^ payload_in.tlast;

  // Held low for the first cycle after reset release so no source ready
  // can be granted while rst_n is still asserted.
  logic run_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  // ---------------------------------------------------------------- TX
  tx_state_e tx_state_q, tx_state_d;
  byte_t     hdr_q, hdr_d;
  byte_t     b1_q, b1_d;
  byte_t     b2_q, b2_d;
  byte_t     txd_q, txd_d;
  logic      txv_q, txv_d;
  logic      txl_q, txl_d;

  logic gnt_info, gnt_instr, gnt_pay, gnt_eth, gnt_parrot, gnt_any;

  always_comb begin
    gnt_info   = 1'b0;
    gnt_instr  = 1'b0;
    gnt_pay    = 1'b0;
    gnt_eth    = 1'b0;
    gnt_parrot = 1'b0;
    if (run_q && (tx_state_q == TX_IDLE)) begin
      if (info_valid)            gnt_info   = 1'b1;
      else if (instr_in.tvalid)  gnt_instr  = 1'b1;
      else if (payload_in.tvalid) gnt_pay   = 1'b1;
      else if (eth_in.tvalid)    gnt_eth    = 1'b1;
      else if (parrot_req)       gnt_parrot = 1'b1;
    end
  end

  assign gnt_any = gnt_info | gnt_instr | gnt_pay | gnt_eth | gnt_parrot;

  assign info_ready        = gnt_info;
  assign instr_in.tready   = gnt_instr;
  assign payload_in.tready = gnt_pay;
  assign eth_in.tready     = gnt_eth;
  assign parrot_ready      = gnt_parrot;

  always_comb begin
    tx_state_d = tx_state_q;
    hdr_d      = hdr_q;
    b1_d       = b1_q;
    b2_d       = b2_q;
    txd_d      = txd_q;
    txv_d      = txv_q;
    txl_d      = txl_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (gnt_any) begin
          b2_d = '0;
          if (gnt_info) begin
            hdr_d = T_INFO;
            b1_d  = byte_t'(info_addr);
            b2_d  = byte_t'(info_data);
          end else if (gnt_instr) begin
            hdr_d = T_INSTR;
            b1_d  = instr_in.tdata;
          end else if (gnt_pay) begin
            hdr_d = T_PAYLOAD;
            b1_d  = payload_in.tdata;
          end else if (gnt_eth) begin
            hdr_d = T_ETH_IN;
            b1_d  = eth_in.tdata;
          end else begin
            hdr_d = T_PARROT;
            b1_d  = '0;
          end
          tx_state_d = TX_HDR;
          txd_d      = hdr_d;
          txv_d      = 1'b1;
          txl_d      = gnt_parrot;
        end
      end
      TX_HDR: begin
        if (uart_tx.tready) begin
          if (hdr_q == T_PARROT) begin
            tx_state_d = TX_IDLE;
            txv_d      = 1'b0;
            txl_d      = 1'b0;
          end else begin
            tx_state_d = TX_B1;
            txd_d      = b1_q;
            txl_d      = (hdr_q != T_INFO);
          end
        end
      end
      TX_B1: begin
        if (uart_tx.tready) begin
          if (hdr_q == T_INFO) begin
            tx_state_d = TX_B2;
            txd_d      = b2_q;
            txl_d      = 1'b1;
          end else begin
            tx_state_d = TX_IDLE;
            txv_d      = 1'b0;
            txl_d      = 1'b0;
          end
        end
      end
      TX_B2: begin
        if (uart_tx.tready) begin
          tx_state_d = TX_IDLE;
          txv_d      = 1'b0;
          txl_d      = 1'b0;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        txv_d      = 1'b0;
        txl_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      hdr_q      <= '0;
      b1_q       <= '0;
      b2_q       <= '0;
      txd_q      <= '0;
      txv_q      <= 1'b0;
      txl_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      hdr_q      <= hdr_d;
      b1_q       <= b1_d;
      b2_q       <= b2_d;
      txd_q      <= txd_d;
      txv_q      <= txv_d;
      txl_q      <= txl_d;
    end
  end

  assign uart_tx.tdata  = txd_q;
  assign uart_tx.tvalid = txv_q;
  assign uart_tx.tlast  = txl_q;

  // ---------------------------------------------------------------- RX
  // sel/vld bit order: 0 echo (type 0), 1 eth (type 2), 2 rest (type 3),
  // 3 status (type 5).
  rx_state_e            rx_state_q, rx_state_d;
  logic                 rx_rdy_q, rx_rdy_d;
  logic [3:0]           rx_sel_q, rx_sel_d;
  logic [3:0]           out_vld_q, out_vld_d;
  byte_t                out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic rx_fire;
  logic out_fire;

  assign rx_fire  = uart_rx.tvalid & rx_rdy_q;
  assign out_fire = |(out_vld_q & {status_out.tready, rest_out.tready,
                                   eth_out.tready, echo_out.tready});

  always_comb begin
    rx_state_d = rx_state_q;
    rx_sel_d   = rx_sel_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    cnt_d      = cnt_q;
    unique case (rx_state_q)
      RX_HDR: begin
        if (rx_fire) begin
          rx_state_d = RX_DATA;
          unique case (uart_rx.tdata)
            T_PARROT:  rx_sel_d = 4'b0001;
            T_ETH_OUT: rx_sel_d = 4'b0010;
            T_REST:    rx_sel_d = 4'b0100;
            T_STATUS:  rx_sel_d = 4'b1000;
            default: begin
              rx_state_d = RX_HDR;
              if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_d = cnt_q + CNT_WIDTH'(1);
            end
          endcase
        end
      end
      RX_DATA: begin
        if (rx_fire) begin
          rx_state_d = RX_OUT;
          out_data_d = uart_rx.tdata;
          out_vld_d  = rx_sel_q;
        end
      end
      RX_OUT: begin
        if (out_fire) begin
          rx_state_d = RX_HDR;
          out_vld_d  = '0;
        end
      end
      default: begin
        rx_state_d = RX_HDR;
        out_vld_d  = '0;
      end
    endcase
    // uart_rx is accepted in every state except while a byte is parked
    // on an output stream.
    rx_rdy_d = (rx_state_d != RX_OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_HDR;
      rx_rdy_q   <= 1'b0;
      rx_sel_q   <= '0;
      out_vld_q  <= '0;
      out_data_q <= '0;
      cnt_q      <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_rdy_q   <= rx_rdy_d;
      rx_sel_q   <= rx_sel_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign uart_rx.tready = rx_rdy_q;

  assign echo_out.tdata    = out_data_q;
  assign echo_out.tvalid   = out_vld_q[0];
  assign echo_out.tlast    = 1'b0;
  assign eth_out.tdata     = out_data_q;
  assign eth_out.tvalid    = out_vld_q[1];
  assign eth_out.tlast     = 1'b0;
  assign rest_out.tdata    = out_data_q;
  assign rest_out.tvalid   = out_vld_q[2];
  assign rest_out.tlast    = 1'b0;
  assign status_out.tdata  = out_data_q;
  assign status_out.tvalid = out_vld_q[3];
  assign status_out.tlast  = 1'b0;

  assign bad_hdr_cnt = cnt_q;

endmodule

// File: tb/tb_uart_link_host.sv
module tb_uart_link_host;

  logic       clk;
  logic       rst_n;
  logic       info_valid;
  logic       info_ready;
  logic [4:0] info_addr;
  logic [7:0] info_data;
  logic       parrot_req;
  logic       parrot_ready;
  logic [7:0] bad_hdr_cnt;

  axi_stream_if #(.DATA_WIDTH(8)) tx_if ();
  axi_stream_if #(.DATA_WIDTH(8)) rx_if ();
  axi_stream_if #(.DATA_WIDTH(8)) instr_if ();
  axi_stream_if #(.DATA_WIDTH(8)) eth_if ();
  axi_stream_if #(.DATA_WIDTH(8)) pay_if ();
  axi_stream_if #(.DATA_WIDTH(8)) rest_if ();
  axi_stream_if #(.DATA_WIDTH(8)) etho_if ();
  axi_stream_if #(.DATA_WIDTH(8)) stat_if ();
  axi_stream_if #(.DATA_WIDTH(8)) echo_if ();

  uart_link_host #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .uart_tx      (tx_if),
    .uart_rx      (rx_if),
    .instr_in     (instr_if),
    .eth_in       (eth_if),
    .payload_in   (pay_if),
    .info_valid   (info_valid),
    .info_ready   (info_ready),
    .info_addr    (info_addr),
    .info_data    (info_data),
    .parrot_req   (parrot_req),
    .parrot_ready (parrot_ready),
    .rest_out     (rest_if),
    .eth_out      (etho_if),
    .status_out   (stat_if),
    .echo_out     (echo_if),
    .bad_hdr_cnt  (bad_hdr_cnt)
  );

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  logic [8:0]  txq[$];   // {tlast, tdata} of accepted uart_tx bytes
  int          txc[$];   // cycle of each accepted uart_tx byte
  logic [10:0] rxq[$];   // {type, data} of accepted output-stream bytes
  int instr_hs  = 0;
  int instr_cyc = 0;
  int rx_tlast  = 0;
  int rx_multi  = 0;
  int src_to    = 0;
  int rx_to     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_if.tvalid && tx_if.tready) begin
        txq.push_back({tx_if.tlast, tx_if.tdata});
        txc.push_back(cyc);
      end
      if (instr_if.tvalid && instr_if.tready) begin
        instr_hs++;
        instr_cyc = cyc;
      end
      if (echo_if.tvalid && echo_if.tready) rxq.push_back({3'd0, echo_if.tdata});
      if (etho_if.tvalid && etho_if.tready) rxq.push_back({3'd2, etho_if.tdata});
      if (rest_if.tvalid && rest_if.tready) rxq.push_back({3'd3, rest_if.tdata});
      if (stat_if.tvalid && stat_if.tready) rxq.push_back({3'd5, stat_if.tdata});
      if (echo_if.tlast || etho_if.tlast || rest_if.tlast || stat_if.tlast) rx_tlast++;
      if ((32'(echo_if.tvalid) + 32'(etho_if.tvalid) + 32'(rest_if.tvalid)
           + 32'(stat_if.tvalid)) > 1) rx_multi++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Holds every asserted source valid until its ready is seen, then drops it.
  task automatic run_sources(input int max_cyc);
    logic g_info, g_instr, g_pay, g_eth, g_par;
    for (int i = 0; i < max_cyc; i++) begin
      if (!(info_valid || instr_if.tvalid || pay_if.tvalid || eth_if.tvalid || parrot_req))
        return;
      @(negedge clk);
      g_info  = info_valid && info_ready;
      g_instr = instr_if.tvalid && instr_if.tready;
      g_pay   = pay_if.tvalid && pay_if.tready;
      g_eth   = eth_if.tvalid && eth_if.tready;
      g_par   = parrot_req && parrot_ready;
      @(posedge clk); #1;
      if (g_info)  info_valid = 1'b0;
      if (g_instr) instr_if.tvalid = 1'b0;
      if (g_pay)   pay_if.tvalid = 1'b0;
      if (g_eth)   eth_if.tvalid = 1'b0;
      if (g_par)   parrot_req = 1'b0;
    end
    if (info_valid || instr_if.tvalid || pay_if.tvalid || eth_if.tvalid || parrot_req) begin
      src_to++;
      info_valid = 1'b0; instr_if.tvalid = 1'b0; pay_if.tvalid = 1'b0;
      eth_if.tvalid = 1'b0; parrot_req = 1'b0;
    end
  endtask

  task automatic rx_send(input logic [7:0] b);
    logic done;
    done = 1'b0;
    rx_if.tdata  = b;
    rx_if.tvalid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = rx_if.tready;
      @(posedge clk); #1;
    end
    rx_if.tvalid = 1'b0;
    if (!done) rx_to++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    info_valid = 1'b1; info_addr = 5'd3; info_data = 8'h99;
    instr_if.tvalid = 1'b1; instr_if.tdata = 8'h12;
    parrot_req = 1'b1;
    #13;
    vecs++;
    if ({tx_if.tvalid, tx_if.tlast, rx_if.tready} !== 3'b000) begin
      errs++; $display("FAIL reset_uart: got %b required 000", {tx_if.tvalid, tx_if.tlast, rx_if.tready});
    end
    vecs++;
    if ({info_ready, instr_if.tready, parrot_ready, pay_if.tready, eth_if.tready} !== 5'b0) begin
      errs++; $display("FAIL reset_src_ready: got %b required 00000",
                       {info_ready, instr_if.tready, parrot_ready, pay_if.tready, eth_if.tready});
    end
    vecs++;
    if ({echo_if.tvalid, etho_if.tvalid, rest_if.tvalid, stat_if.tvalid} !== 4'b0) begin
      errs++; $display("FAIL reset_out_valid: got %b required 0000",
                       {echo_if.tvalid, etho_if.tvalid, rest_if.tvalid, stat_if.tvalid});
    end
    vecs++;
    if (bad_hdr_cnt !== 8'd0) begin
      errs++; $display("FAIL reset_cnt: got %0d required 0", bad_hdr_cnt);
    end
    info_valid = 1'b0; instr_if.tvalid = 1'b0; parrot_req = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    idle(3);
    vecs++;
    if ({tx_if.tvalid, rx_if.tready} !== 2'b01) begin
      errs++; $display("FAIL post_reset_idle: got %b required 01", {tx_if.tvalid, rx_if.tready});
    end
  endtask

  task automatic test_instr;
    txq.delete(); txc.delete(); instr_hs = 0;
    instr_if.tdata = 8'hA5; instr_if.tvalid = 1'b1;
    run_sources(10);
    idle(4);
    vecs++;
    if (txq.size() !== 2) begin
      errs++; $display("FAIL instr_len: got %0d bytes required 2", txq.size());
    end
    vecs++;
    if (txq[0] !== 9'h004) begin
      errs++; $display("FAIL instr_hdr: got %h required 004", txq[0]);
    end
    vecs++;
    if (txq[1] !== 9'h1A5) begin
      errs++; $display("FAIL instr_data: got %h required 1a5", txq[1]);
    end
    vecs++;
    if ((txc[0] - instr_cyc) !== 1 || (txc[1] - txc[0]) !== 1) begin
      errs++; $display("FAIL instr_timing: got gaps %0d,%0d required 1,1",
                       txc[0] - instr_cyc, txc[1] - txc[0]);
    end
    vecs++;
    if (instr_hs !== 1) begin
      errs++; $display("FAIL instr_ready_pulses: got %0d required 1", instr_hs);
    end
  endtask

  task automatic test_priority;
    logic [8:0] exp_q [5];
    exp_q[0] = 9'h007; exp_q[1] = 9'h015; exp_q[2] = 9'h150;
    exp_q[3] = 9'h001; exp_q[4] = 9'h111;
    txq.delete(); txc.delete();
    info_addr = 5'd21; info_data = 8'h50; info_valid = 1'b1;
    eth_if.tdata = 8'h11; eth_if.tvalid = 1'b1;
    run_sources(20);
    idle(5);
    vecs++;
    if (txq.size() !== 5) begin
      errs++; $display("FAIL prio_len: got %0d bytes required 5", txq.size());
    end
    for (int i = 0; i < 5; i++) begin
      vecs++;
      if (txq[i] !== exp_q[i]) begin
        errs++; $display("FAIL prio_byte%0d: got %h required %h", i, txq[i], exp_q[i]);
      end
    end
    vecs++;
    if ((txc[3] - txc[0]) !== 4) begin
      errs++; $display("FAIL info_rate: got %0d cycles required 4", txc[3] - txc[0]);
    end
  endtask

  task automatic test_parrot_backpressure;
    int holds;
    holds = 0;
    txq.delete(); txc.delete();
    parrot_req = 1'b1;
    run_sources(10);
    for (int i = 0; i < 8; i++) begin
      tx_if.tready = (i % 2 == 1);
      @(negedge clk);
      if (tx_if.tvalid && !tx_if.tready) begin
        holds++;
        vecs++;
        if ({tx_if.tlast, tx_if.tdata} !== 9'h100) begin
          errs++; $display("FAIL parrot_hold: got %h required 100", {tx_if.tlast, tx_if.tdata});
        end
      end
      @(posedge clk); #1;
    end
    tx_if.tready = 1'b1;
    idle(3);
    vecs++;
    if (txq.size() !== 1 || txq[0] !== 9'h100) begin
      errs++; $display("FAIL parrot_once: got %0d bytes first %h required 1 byte 100",
                       txq.size(), txq[0]);
    end
    vecs++;
    if (holds == 0) begin
      errs++; $display("FAIL parrot_stall: got 0 held cycles required at least 1");
    end
  endtask

  task automatic test_rx_routing;
    rxq.delete();
    rx_tlast = 0; rx_multi = 0;
    rx_send(8'h02); rx_send(8'h3C);
    rx_send(8'h05); rx_send(8'h81);
    rx_send(8'h00); rx_send(8'h00);
    idle(4);
    vecs++;
    if (rxq.size() !== 3) begin
      errs++; $display("FAIL rx_count: got %0d required 3", rxq.size());
    end
    vecs++;
    if (rxq[0] !== 11'h23C) begin
      errs++; $display("FAIL rx_eth: got %h required 23c", rxq[0]);
    end
    vecs++;
    if (rxq[1] !== 11'h581) begin
      errs++; $display("FAIL rx_status: got %h required 581", rxq[1]);
    end
    vecs++;
    if (rxq[2] !== 11'h000) begin
      errs++; $display("FAIL rx_echo: got %h required 000", rxq[2]);
    end
    vecs++;
    if (rx_multi !== 0 || rx_tlast !== 0 || rx_to !== 0) begin
      errs++; $display("FAIL rx_clean: got multi=%0d tlast=%0d timeouts=%0d required 0,0,0",
                       rx_multi, rx_tlast, rx_to);
    end
  endtask

  task automatic test_bad_hdr;
    logic [7:0] bad [6];
    bad[0] = 8'h09; bad[1] = 8'h01; bad[2] = 8'h04;
    bad[3] = 8'h06; bad[4] = 8'h07; bad[5] = 8'hFF;
    rxq.delete();
    rx_send(8'h09); rx_send(8'h03); rx_send(8'h77);
    idle(3);
    vecs++;
    if (bad_hdr_cnt !== 8'd1) begin
      errs++; $display("FAIL bad_cnt_one: got %0d required 1", bad_hdr_cnt);
    end
    vecs++;
    if (rxq.size() !== 1 || rxq[0] !== 11'h377) begin
      errs++; $display("FAIL rest_after_bad: got %0d entries first %h required 1 entry 377",
                       rxq.size(), rxq[0]);
    end
    for (int i = 0; i < 253; i++) rx_send(bad[i % 6]);
    idle(1);
    vecs++;
    if (bad_hdr_cnt !== 8'd254) begin
      errs++; $display("FAIL bad_cnt_254: got %0d required 254", bad_hdr_cnt);
    end
    rx_send(8'h0A);
    idle(1);
    vecs++;
    if (bad_hdr_cnt !== 8'd255) begin
      errs++; $display("FAIL bad_cnt_255: got %0d required 255", bad_hdr_cnt);
    end
    for (int i = 0; i < 45; i++) rx_send(bad[i % 6]);
    idle(1);
    vecs++;
    if (bad_hdr_cnt !== 8'd255 || rx_to !== 0) begin
      errs++; $display("FAIL bad_cnt_sat: got %0d (timeouts %0d) required 255 (0)", bad_hdr_cnt, rx_to);
    end
  endtask

  task automatic test_reset_mid;
    rest_if.tready = 1'b0;
    rx_send(8'h03); rx_send(8'h44);
    idle(2);
    vecs++;
    if ({rest_if.tvalid, rest_if.tdata} !== 9'h144) begin
      errs++; $display("FAIL rx_out_held: got %h required 144", {rest_if.tvalid, rest_if.tdata});
    end
    pay_if.tdata = 8'h5A; pay_if.tvalid = 1'b1;
    run_sources(10);
    @(posedge clk); #1;
    tx_if.tready = 1'b0;
    idle(1);
    vecs++;
    if ({tx_if.tvalid, tx_if.tlast, tx_if.tdata} !== 10'h35A) begin
      errs++; $display("FAIL tx_b1_held: got %h required 35a", {tx_if.tvalid, tx_if.tlast, tx_if.tdata});
    end
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if ({tx_if.tvalid, rest_if.tvalid, rx_if.tready, tx_if.tlast} !== 4'b0000) begin
      errs++; $display("FAIL mid_reset_drop: got %b required 0000",
                       {tx_if.tvalid, rest_if.tvalid, rx_if.tready, tx_if.tlast});
    end
    @(negedge clk) rst_n = 1'b1;
    tx_if.tready = 1'b1; rest_if.tready = 1'b1;
    idle(3);
    txq.delete(); txc.delete(); rxq.delete();
    instr_if.tdata = 8'h33; instr_if.tvalid = 1'b1;
    run_sources(10);
    idle(4);
    vecs++;
    if (txq.size() !== 2 || txq[0] !== 9'h004 || txq[1] !== 9'h133) begin
      errs++; $display("FAIL clean_restart_tx: got %0d bytes %h %h required 2 bytes 004 133",
                       txq.size(), txq[0], txq[1]);
    end
    rx_send(8'h05); rx_send(8'h12);
    idle(3);
    vecs++;
    if (rxq.size() !== 1 || rxq[0] !== 11'h512) begin
      errs++; $display("FAIL clean_restart_rx: got %0d entries first %h required 1 entry 512",
                       rxq.size(), rxq[0]);
    end
    vecs++;
    if (src_to !== 0 || rx_to !== 0) begin
      errs++; $display("FAIL handshake_timeouts: got src=%0d rx=%0d required 0,0", src_to, rx_to);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    info_valid = 1'b0; info_addr = '0; info_data = '0; parrot_req = 1'b0;
    instr_if.tvalid = 1'b0; instr_if.tdata = '0; instr_if.tlast = 1'b0;
    eth_if.tvalid = 1'b0; eth_if.tdata = '0; eth_if.tlast = 1'b0;
    pay_if.tvalid = 1'b0; pay_if.tdata = '0; pay_if.tlast = 1'b0;
    rx_if.tvalid = 1'b0; rx_if.tdata = '0; rx_if.tlast = 1'b0;
    tx_if.tready = 1'b1;
    rest_if.tready = 1'b1; etho_if.tready = 1'b1;
    stat_if.tready = 1'b1; echo_if.tready = 1'b1;

    test_reset;
    test_instr;
    test_priority;
    test_parrot_backpressure;
    test_rx_routing;
    test_bad_hdr;
    test_reset_mid;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
